nlp_table: RTL and testbench

- Next-line predictor storage: the responder end of the NLP update channel driven by the IF3 predecoder.
- Accepts IF1 fetch-bundle lookups and returns per-slot nlpInfo (valid, taken, target, bimState) one cycle later, in IF2.
- Applies IF3 training updates: allocate, retarget, 2-bit bimodal counter step.
- Direct-mapped, partial-tagged; runs a post-reset invalidation walk before serving lookups.

---
 rtl/nlp_table.sv | 151 +++++++++++++++
 tb/tb_nlp_table.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nlp_table.sv
// nlp_table: direct-mapped, partial-tagged next-line predictor table with IF1 lookup / IF3 update ports.
// Optional macro NLP_UPD_BYPASS_EN forwards a same-cycle update into colliding lookup slots.
module nlp_table #(
    parameter int ENTRIES = 128,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic        lk_stall,
    output logic        nlp0_valid,
    output logic        nlp1_valid,
    output logic        nlp0_taken,
    output logic        nlp1_taken,
    output logic [31:0] nlp0_target,
    output logic [31:0] nlp1_target,
    output logic [1:0]  nlp0_bim,
    output logic [1:0]  nlp1_bim,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_bim,
    input  logic        upd_should_take
);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_LO + TAG_W;
    localparam logic [IDX_W-1:0] WALK_LAST = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   walk_r;
    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r [ENTRIES];
    logic [29:0]        tgt_r [ENTRIES];
    logic [1:0]         bim_r [ENTRIES];

    function automatic logic [1:0] sat_inc(input logic [1:0] b);
        if (b == 2'b11) return 2'b11;
        else            return b + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] b);
        if (b == 2'b00) return 2'b00;
        else            return b - 2'b01;
    endfunction

    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             upd_hit_s;
    logic             upd_wr_s;
    logic [1:0]       upd_bim_new_s;

    assign upd_idx_s     = upd_pc[TAG_LO-1:2];
    assign upd_tag_s     = upd_pc[TAG_LO +: TAG_W];
    assign upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    assign upd_bim_new_s = upd_should_take ? sat_inc(upd_bim) : sat_dec(upd_bim);
    // A not-taken miss never allocates, so cold not-taken branches cannot evict useful entries.
    assign upd_wr_s      = (state_r == RUN) && upd_valid && (upd_hit_s || upd_should_take);

    logic [31:0] slot_pc_s  [2];
    logic        slot_hit_s [2];
    logic [29:0] slot_tgt_s [2];
    logic [1:0]  slot_bim_s [2];
    logic        lk_on_s;

    assign slot_pc_s[0] = lk_pc;
    assign slot_pc_s[1] = lk_pc + 32'd4;
    assign lk_on_s      = (state_r == RUN) && lk_valid;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        logic [IDX_W-1:0] idx_s;
        logic [TAG_W-1:0] tag_s;
        logic             byp_s;
        assign idx_s = slot_pc_s[s][TAG_LO-1:2];
        assign tag_s = slot_pc_s[s][TAG_LO +: TAG_W];
`ifdef NLP_UPD_BYPASS_EN
        assign byp_s = upd_wr_s && (upd_idx_s == idx_s);
`else
        assign byp_s = 1'b0;
`endif
        assign slot_hit_s[s] = byp_s ? (upd_tag_s == tag_s)
                                     : (valid_r[idx_s] && (tag_r[idx_s] == tag_s));
        assign slot_tgt_s[s] = byp_s ? upd_target[31:2] : tgt_r[idx_s];
        assign slot_bim_s[s] = byp_s ? upd_bim_new_s : bim_r[idx_s];
    end

    logic unused_bits_s;
    assign unused_bits_s = ^{slot_pc_s[0][1:0], slot_pc_s[0][31:TAG_HI],
                             slot_pc_s[1][1:0], slot_pc_s[1][31:TAG_HI],
                             upd_pc[1:0], upd_pc[31:TAG_HI], upd_target[1:0]};

    // Control FSM: invalidation walk, valid bits and the registered IF2 lookup outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= CLEAR;
            walk_r      <= {IDX_W{1'b0}};
            ready       <= 1'b0;
            nlp0_valid  <= 1'b0;
            nlp1_valid  <= 1'b0;
            nlp0_taken  <= 1'b0;
            nlp1_taken  <= 1'b0;
            nlp0_target <= 32'd0;
            nlp1_target <= 32'd0;
            nlp0_bim    <= 2'b01;
            nlp1_bim    <= 2'b01;
        end else begin
            case (state_r)
                CLEAR: begin
                    valid_r[walk_r] <= 1'b0;
                    walk_r          <= walk_r + IDX_ONE;
                    if (walk_r == WALK_LAST) begin
                        state_r <= RUN;
                        ready   <= 1'b1;
                    end
                end
                RUN: begin
                    if (upd_wr_s) valid_r[upd_idx_s] <= 1'b1;
                end
                default: begin
                    state_r <= CLEAR;
                    walk_r  <= {IDX_W{1'b0}};
                    ready   <= 1'b0;
                end
            endcase
            if (!lk_stall) begin
                nlp0_valid  <= lk_on_s && slot_hit_s[0];
                nlp1_valid  <= lk_on_s && slot_hit_s[1];
                nlp0_taken  <= lk_on_s && slot_hit_s[0] && slot_bim_s[0][1];
                nlp1_taken  <= lk_on_s && slot_hit_s[1] && slot_bim_s[1][1];
                nlp0_target <= (lk_on_s && slot_hit_s[0]) ? {slot_tgt_s[0], 2'b00} : 32'd0;
                nlp1_target <= (lk_on_s && slot_hit_s[1]) ? {slot_tgt_s[1], 2'b00} : 32'd0;
                nlp0_bim    <= (lk_on_s && slot_hit_s[0]) ? slot_bim_s[0] : 2'b01;
                nlp1_bim    <= (lk_on_s && slot_hit_s[1]) ? slot_bim_s[1] : 2'b01;
            end
        end
    end

    // Entry payload storage; validity lives in valid_r so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (rst && upd_wr_s) begin
            tag_r[upd_idx_s] <= upd_tag_s;
            tgt_r[upd_idx_s] <= upd_target[31:2];
            bim_r[upd_idx_s] <= upd_bim_new_s;
        end
    end
endmodule

// File: tb/tb_nlp_table.sv
// Self-checking bench for nlp_table: directed walk/allocate/saturate/alias/collision/stall steps, then random traffic vs. an entry-array model.
module tb_nlp_table;
    logic        clk = 1'b0;
    logic        rst, ready, lk_valid, lk_stall;
    logic [31:0] lk_pc;
    logic        nlp0_valid, nlp1_valid, nlp0_taken, nlp1_taken;
    logic [31:0] nlp0_target, nlp1_target;
    logic [1:0]  nlp0_bim, nlp1_bim;
    logic        upd_valid, upd_should_take;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_bim;

    int total = 0;
    int bad   = 0;

    localparam logic [35:0] MISS = {1'b0, 1'b0, 32'd0, 2'b01};

    // Model of table contents, indexed by the PC rules directly.
    bit          m_valid [128];
    logic [9:0]  m_tag   [128];
    logic [31:0] m_tgt   [128];
    logic [1:0]  m_bim   [128];
    logic [35:0] exp_slot [2];

    always #5 clk = ~clk;

    nlp_table dut (
        .clk(clk), .rst(rst), .ready(ready),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_stall(lk_stall),
        .nlp0_valid(nlp0_valid), .nlp1_valid(nlp1_valid),
        .nlp0_taken(nlp0_taken), .nlp1_taken(nlp1_taken),
        .nlp0_target(nlp0_target), .nlp1_target(nlp1_target),
        .nlp0_bim(nlp0_bim), .nlp1_bim(nlp1_bim),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_bim(upd_bim), .upd_should_take(upd_should_take)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd127);
    endfunction

    function automatic logic [9:0] tag_of(input logic [31:0] pc);
        return 10'((pc >> 9) & 32'd1023);
    endfunction

    function automatic logic [1:0] step(input logic [1:0] b, input logic take);
        int v;
        v = int'(b) + (take ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    function automatic logic [35:0] slot0();
        return {nlp0_valid, nlp0_taken, nlp0_target, nlp0_bim};
    endfunction

    function automatic logic [35:0] slot1();
        return {nlp1_valid, nlp1_taken, nlp1_target, nlp1_bim};
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: predict outputs from the model, drive, check, then train the model.
    task automatic cyc(input logic lv, input logic [31:0] lpc, input logic st,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic [1:0] ubim, input logic utake, input string tag);
        int          ui, i;
        logic [9:0]  ut, t;
        logic        hit_u, wr, h;
        logic [1:0]  nb, b;
        logic [31:0] p, tg;
        ui    = idx_of(upc);
        ut    = tag_of(upc);
        hit_u = m_valid[ui] && (m_tag[ui] == ut);
        nb    = step(ubim, utake);
        wr    = uv && (hit_u || utake);
        if (!st) begin
            for (int s = 0; s < 2; s++) begin
                p  = lpc + 32'(4 * s);
                i  = idx_of(p);
                t  = tag_of(p);
                h  = m_valid[i] && (m_tag[i] == t);
                tg = m_tgt[i];
                b  = m_bim[i];
`ifdef NLP_UPD_BYPASS_EN
                if (wr && (ui == i)) begin
                    h  = (ut == t);
                    tg = utgt & 32'hFFFF_FFFC;
                    b  = nb;
                end
`endif
                exp_slot[s] = (lv && h) ? {1'b1, b[1], tg, b} : MISS;
            end
        end
        lk_valid = lv; lk_pc = lpc; lk_stall = st;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_bim = ubim; upd_should_take = utake;
        tick();
        lk_valid = 1'b0; lk_stall = 1'b0; upd_valid = 1'b0;
        check({tag, "_ready"}, {35'd0, ready}, 36'd1);
        check({tag, "_s0"}, slot0(), exp_slot[0]);
        check({tag, "_s1"}, slot1(), exp_slot[1]);
        if (wr) begin
            m_valid[ui] = 1'b1;
            m_tag[ui]   = ut;
            m_tgt[ui]   = utgt & 32'hFFFF_FFFC;
            m_bim[ui]   = nb;
        end
    endtask

    task automatic do_lookup(input logic [31:0] pc, input string tag);
        cyc(1'b1, pc, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 1'b0, tag);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic [1:0] b, input logic take, input string tag);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, pc, tgt, b, take, tag);
    endtask

    initial begin
        int          low;
        logic [31:0] pc_a, pc_b, tgt;
        logic [35:0] coll_exp;
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        rst = 1'b0; lk_valid = 1'b0; lk_pc = 32'd0; lk_stall = 1'b0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0; upd_bim = 2'b01; upd_should_take = 1'b0;

        // Reset and invalidation walk.
        tick();
        check("rst_ready", {35'd0, ready}, 36'd0);
        check("rst_s0", slot0(), MISS);
        check("rst_s1", slot1(), MISS);
        rst = 1'b1;
        low = 1;
        for (int c = 1; c <= 200; c++) begin
            lk_valid = (c == 50);
            lk_pc    = 32'h8000_0100;
            tick();
            lk_valid = 1'b0;
            if (c == 50) check("walk_lookup", slot0(), MISS);
            if (ready) break;
            low++;
        end
        check("walk_len", 36'(low), 36'd128);
        exp_slot[0] = MISS;
        exp_slot[1] = MISS;

        // Allocate and hit.
        do_update(32'h8000_0100, 32'h8000_0200, 2'b01, 1'b1, "alloc");
        do_lookup(32'h8000_0100, "alloc_hit");
        check("alloc_const", slot0(), {1'b1, 1'b1, 32'h8000_0200, 2'b10});
        check("alloc_slot1", slot1(), MISS);

        // Saturation up, then step down.
        for (int k = 0; k < 3; k++) do_update(32'h8000_0100, 32'h8000_0200, 2'b10, 1'b1, "sat_up");
        do_lookup(32'h8000_0100, "sat_hi");
        check("sat_hi_const", slot0(), {1'b1, 1'b1, 32'h8000_0200, 2'b11});
        do_update(32'h8000_0100, 32'h8000_0200, 2'b11, 1'b0, "dn1");
        do_lookup(32'h8000_0100, "dn1_lk");
        check("dn1_const", slot0(), {1'b1, 1'b1, 32'h8000_0200, 2'b10});
        do_update(32'h8000_0100, 32'h8000_0200, 2'b10, 1'b0, "dn2");
        do_lookup(32'h8000_0100, "dn2_lk");
        check("dn2_const", slot0(), {1'b1, 1'b0, 32'h8000_0200, 2'b01});

        // Not-taken miss never allocates.
        do_update(32'h8000_0300, 32'h8000_0500, 2'b01, 1'b0, "noalloc");
        do_lookup(32'h8000_0300, "noalloc_lk");
        check("noalloc_const", slot0(), MISS);

        // Aliasing above the tag hits; same index with a different tag misses.
        do_lookup(32'h8008_0100, "alias_hi");
        check("alias_hi_const", slot0(), {1'b1, 1'b0, 32'h8000_0200, 2'b01});
        do_lookup(32'h8000_0300, "alias_tag");
        check("alias_tag_const", slot0(), MISS);

        // Same-cycle update and lookup of one index.
        cyc(1'b1, 32'h8000_0400, 1'b0, 1'b1, 32'h8000_0400, 32'h8000_0600, 2'b01, 1'b1, "collide");
`ifdef NLP_UPD_BYPASS_EN
        coll_exp = {1'b1, 1'b1, 32'h8000_0600, 2'b10};
`else
        coll_exp = MISS;
`endif
        check("collide_const", slot0(), coll_exp);

        // Stall holds outputs while lk_pc changes.
        do_lookup(32'h8000_0100, "pre_stall");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h8000_0400 + 32'(16 * k), 1'b1, 1'b0, 32'd0, 32'd0, 2'b01, 1'b0, "stall");
            check("stall_const", slot0(), {1'b1, 1'b0, 32'h8000_0200, 2'b01});
        end

        // Random traffic over a small PC pool, including index wrap at 127 -> 0.
        for (int n = 0; n < 400; n++) begin
            int ia, ib;
            ia   = $urandom_range(0, 7);
            ib   = $urandom_range(0, 7);
            pc_a = 32'h8000_0000 + 32'($urandom_range(0, 1) << 9)
                 + 32'(((ia < 4) ? ia : 120 + ia) << 2);
            pc_b = 32'h8000_0000 + 32'($urandom_range(0, 1) << 9)
                 + 32'(((ib < 4) ? ib : 120 + ib) << 2);
            tgt  = $urandom();
            cyc(1'($urandom_range(0, 1)), pc_a, ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), pc_b, tgt, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
